// File: rtl/dds_tone_generator.sv
// Multi-channel DDS tone source: per-channel phase accumulator, quarter-wave sine
// lookup and amplitude scaling in a 3-stage pipeline (phase, lookup, scale).
// Optional feature macro: DDS_SUM_OUT_EN adds the registered full-precision sum_out port.
`timescale 1ns/1ps
module dds_tone_generator #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned PHASE_WIDTH    = 32,
  parameter int unsigned LUT_ADDR_WIDTH = 10,
  parameter int unsigned NUM_CH         = 2,
  localparam int unsigned CH_WIDTH      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned SUM_WIDTH     = DATA_WIDTH + $clog2(NUM_CH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           sample_en,
  input  logic                           cfg_we,
  input  logic [CH_WIDTH-1:0]            cfg_ch,
  input  logic [1:0]                     cfg_addr,
  input  logic [PHASE_WIDTH-1:0]         cfg_data,
  output logic [NUM_CH*DATA_WIDTH-1:0]   tone_out,
  output logic                           tone_valid
`ifdef DDS_SUM_OUT_EN
  ,
  output logic signed [SUM_WIDTH-1:0]    sum_out
`endif
);

  localparam int unsigned AMP_WIDTH  = 16;
  localparam int unsigned PROD_WIDTH = DATA_WIDTH + AMP_WIDTH + 1;
  localparam int unsigned QUARTER    = 2 ** (LUT_ADDR_WIDTH - 2);
  localparam logic [DATA_WIDTH-1:0] PEAK = {1'b0, {(DATA_WIDTH - 1){1'b1}}};

  // First-quadrant sine entry, rounded to nearest; evaluated at elaboration.
  function automatic logic [DATA_WIDTH-1:0] rom_value(int unsigned idx);
    real ang;
    real val;
    ang = 2.0 * 3.14159265358979323846 * real'(idx) / real'(2 ** LUT_ADDR_WIDTH);
    val = (2.0 ** (DATA_WIDTH - 1) - 1.0) * $sin(ang);
    return DATA_WIDTH'($rtoi(val + 0.5));
  endfunction

  logic [DATA_WIDTH-1:0] rom [QUARTER];
  for (genvar i = 0; i < QUARTER; i++) begin : g_rom
    assign rom[i] = rom_value(i);
  end

  logic                                   sample_ev;
  logic [NUM_CH-1:0]                      wr_sel;
  logic [NUM_CH-1:0][PHASE_WIDTH-1:0]     inc_sh_q, inc_sh_d, inc_q;
  logic [NUM_CH-1:0][AMP_WIDTH-1:0]       amp_sh_q, amp_sh_d, amp_q;
  logic [NUM_CH-1:0][PHASE_WIDTH-1:0]     off_q, off_d, acc_q, acc_d;
  logic [NUM_CH-1:0][LUT_ADDR_WIDTH-1:0]  k1_q, k1_d;
  logic [NUM_CH-1:0][AMP_WIDTH-1:0]       amp1_q, amp2_q;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]      lut_q, lut_d, tone_q, tone_d;
  logic                                   v1_q, v2_q, valid_q;

  assign sample_ev = enable & sample_en;

  // Channel decode; a channel number past NUM_CH matches nothing and is dropped.
  always_comb begin
    wr_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_sel[c] = cfg_we && (cfg_ch == CH_WIDTH'(c));
    end
  end

  // Config write routing and accumulator advance; a phase reset beats the increment.
  always_comb begin
    inc_sh_d = inc_sh_q;
    amp_sh_d = amp_sh_q;
    off_d    = off_q;
    acc_d    = acc_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sample_ev) begin
        acc_d[c] = acc_q[c] + inc_q[c];
      end
      if (wr_sel[c]) begin
        case (cfg_addr)
          2'd0: inc_sh_d[c] = cfg_data;
          2'd1: amp_sh_d[c] = cfg_data[AMP_WIDTH-1:0];
          2'd2: off_d[c]    = cfg_data;
          2'd3: acc_d[c]    = '0;
        endcase
      end
    end
  end

  // Config and accumulator state. Active inc/amp follow the shadow on the same edge,
  // so a sample taken in the write cycle still uses the previous active value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc_sh_q <= '0;
      amp_sh_q <= '0;
      inc_q    <= '0;
      amp_q    <= '0;
      off_q    <= '0;
      acc_q    <= '0;
    end else begin
      inc_sh_q <= inc_sh_d;
      amp_sh_q <= amp_sh_d;
      inc_q    <= inc_sh_d;
      amp_q    <= amp_sh_d;
      off_q    <= off_d;
      acc_q    <= acc_d;
    end
  end

  // S1 lookup address: top bits of (acc + off), truncated.
  always_comb begin
    k1_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      k1_d[c] = LUT_ADDR_WIDTH'((acc_q[c] + off_q[c]) >> (PHASE_WIDTH - LUT_ADDR_WIDTH));
    end
  end

  // S1 register: phase index and the amplitude that belongs to this sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q   <= 1'b0;
      k1_q   <= '0;
      amp1_q <= '0;
    end else begin
      v1_q <= sample_ev;
      if (sample_ev) begin
        k1_q   <= k1_d;
        amp1_q <= amp_q;
      end
    end
  end

  // S2 quadrant fold; the quarter/three-quarter points sit just past the ROM end.
  always_comb begin
    logic [LUT_ADDR_WIDTH-3:0] idx;
    logic [DATA_WIDTH-1:0]     mag;
    lut_d = '0;
    idx   = '0;
    mag   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      idx = k1_q[c][LUT_ADDR_WIDTH-2] ? -k1_q[c][LUT_ADDR_WIDTH-3:0]
                                      : k1_q[c][LUT_ADDR_WIDTH-3:0];
      mag = (k1_q[c][LUT_ADDR_WIDTH-2] && (k1_q[c][LUT_ADDR_WIDTH-3:0] == '0)) ? PEAK
                                                                              : rom[idx];
      lut_d[c] = k1_q[c][LUT_ADDR_WIDTH-1] ? -mag : mag;
    end
  end

  // S2 register: signed sine value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_q   <= 1'b0;
      lut_q  <= '0;
      amp2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        lut_q  <= lut_d;
        amp2_q <= amp1_q;
      end
    end
  end

  // S3 scale: signed lut times unsigned amp, arithmetic shift gives floor rounding.
  always_comb begin
    logic signed [PROD_WIDTH-1:0] prod;
    tone_d = '0;
    prod   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      prod = $signed({{(AMP_WIDTH + 1){lut_q[c][DATA_WIDTH-1]}}, lut_q[c]}) *
             $signed({{(DATA_WIDTH + 1){1'b0}}, amp2_q[c]});
      tone_d[c] = DATA_WIDTH'(prod >>> AMP_WIDTH);
    end
  end

`ifdef DDS_SUM_OUT_EN
  logic signed [SUM_WIDTH-1:0] sum_q, sum_d;

  // Full-precision channel sum, no saturation.
  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sum_d = sum_d + SUM_WIDTH'($signed(tone_d[c]));
    end
  end
`endif

  // S3 output register; outputs only move on a valid cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      tone_q  <= '0;
`ifdef DDS_SUM_OUT_EN
      sum_q   <= '0;
`endif
    end else begin
      valid_q <= v2_q;
      if (v2_q) begin
        tone_q <= tone_d;
`ifdef DDS_SUM_OUT_EN
        sum_q  <= sum_d;
`endif
      end
    end
  end

  assign tone_out   = tone_q;
  assign tone_valid = valid_q;
`ifdef DDS_SUM_OUT_EN
  assign sum_out    = sum_q;
`endif

endmodule
